mc_seq: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath sharing one memory port for fetch and data.

---
 rtl/mc_seq_if.sv | 26 ++
 rtl/mc_seq.sv | 212 +++++++++++++++++++++
 tb/tb_mc_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_seq_if.sv
// Memory-port bundle shared between the sequencer and the single fetch/data
// memory port.
//   mem_req   : access request, held until mem_ready
//   mem_we    : 1 = write access
//   IorD      : address select, 0 = PC, 1 = ALU result
//   mem_ready : memory completes the current access this cycle
interface mc_seq_if;
  logic mem_req;
  logic mem_we;
  logic IorD;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output IorD,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  IorD,
    output mem_ready
  );
endinterface

// File: rtl/mc_seq.sv
// Multi-cycle sequencer for the MIPS datapath. One memory port serves both
// instruction fetch and data access. The combinational decoder still supplies
// the datapath selects. This block decides when IR, MDR, PC, the register file
// and memory are written, and it handles one instruction at a time. It also
// counts retired instructions and halts if the memory port stops answering.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   Op, Funct       : opcode/funct fields from IR (valid from DECODE onward)
//   mem             : memory handshake (mem_req, mem_we, IorD, mem_ready)
//   IRWrite         : load IR from memory read data
//   MDRWrite        : load MDR from memory read data
//   PCWrite         : commit next PC
//   RegWrite        : register file write strobe
//   state           : current state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5)
//   mem_err         : sticky memory-timeout flag
//   instret         : retired-instruction count (wraps)
module mc_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  mc_seq_if.master         mem,
  output logic             IRWrite,
  output logic             MDRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [2:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  // The counter must be able to hold TIMEOUT-1. TIMEOUT=0 disables the check.
  localparam int                WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam bit                TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_ALU   = 3'd1,
    C_LINK  = 3'd2,
    C_BR    = 3'd3,
    C_LOAD  = 3'd4,
    C_STORE = 3'd5
  } iclass_t;

  state_t            state_r;
  state_t            state_next_s;
  iclass_t           cls_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_next_s;
  logic              wait_hit_s;
  logic              timeout_s;
  logic              mem_req_s;
  logic              mem_we_s;
  logic              iord_s;
  logic              ir_write_s;
  logic              mdr_write_s;
  logic              pc_write_s;
  logic              reg_write_s;
  logic              mem_err_r;
  logic [CNT_W-1:0]  instret_r;

  // Instruction class from the opcode and funct fields.
  always_comb begin
    cls_s = C_NOP;
    case (Op)
      6'h00: begin
        case (Funct)
          6'h08:   cls_s = C_BR;    // jr
          6'h09:   cls_s = C_LINK;  // jalr
          default: cls_s = C_ALU;   // remaining R-type
        endcase
      end
      6'h23, 6'h20, 6'h21, 6'h24, 6'h25: cls_s = C_LOAD;
      6'h2B, 6'h28, 6'h29:               cls_s = C_STORE;
      6'h04, 6'h05, 6'h02:               cls_s = C_BR;
      6'h03:                             cls_s = C_LINK;
      6'h08, 6'h0D, 6'h0C, 6'h0A, 6'h0F: cls_s = C_ALU;
      default:                           cls_s = C_NOP;
    endcase
  end

  // This cycle is the last allowed wait. If mem_ready is still low here, the access times out.
  assign wait_hit_s = TIMEOUT_EN && (wait_cnt_r == WAIT_LAST);

  // Next-state logic and control strobes.
  always_comb begin
    state_next_s = state_r;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    mdr_write_s  = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem.mem_ready) begin
          ir_write_s   = 1'b1;
          state_next_s = S_DECODE;
        end else if (wait_hit_s) begin
          timeout_s    = 1'b1;
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: state_next_s = S_EXEC;
      S_EXEC: begin
        case (cls_s)
          C_LOAD, C_STORE: state_next_s = S_MEM;
          C_ALU, C_LINK:   state_next_s = S_WB;
          default: begin
            pc_write_s   = 1'b1;
            state_next_s = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        mem_we_s  = (cls_s == C_STORE);
        if (mem.mem_ready) begin
          if (cls_s == C_STORE) begin
            pc_write_s   = 1'b1;
            state_next_s = S_FETCH;
          end else begin
            mdr_write_s  = 1'b1;
            state_next_s = S_WB;
          end
        end else if (wait_hit_s) begin
          timeout_s    = 1'b1;
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        pc_write_s   = 1'b1;
        state_next_s = S_FETCH;
      end
      S_HALT:  state_next_s = S_HALT;
      default: state_next_s = S_FETCH;
    endcase
  end

  // The wait counter runs only while a request is outstanding. Any other cycle clears it,
  // so it restarts from zero on entry to FETCH or MEM.
  always_comb begin
    if (mem_req_s && !mem.mem_ready) begin
      wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_next_s = '0;
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Sticky timeout flag and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err_r <= 1'b0;
      instret_r <= '0;
    end else begin
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end
      if (pc_write_s) begin
        instret_r <= instret_r + CNT_W'(1);
      end
    end
  end

  // While reset is asserted, the state is already FETCH. Gating with rst drops
  // an in-flight request and all strobes in the same cycle.
  assign mem.mem_req = mem_req_s   & ~rst;
  assign mem.mem_we  = mem_we_s    & ~rst;
  assign mem.IorD    = iord_s;
  assign IRWrite     = ir_write_s  & ~rst;
  assign MDRWrite    = mdr_write_s & ~rst;
  assign PCWrite     = pc_write_s  & ~rst;
  assign RegWrite    = reg_write_s & ~rst;
  assign state       = state_r;
  assign mem_err     = mem_err_r;
  assign instret     = instret_r;

endmodule

// File: tb/tb_mc_seq.sv
module tb_mc_seq;
  localparam int TO = 4;
  localparam int CW = 4;

  localparam int C_NOP = 0, C_ALU = 1, C_LINK = 2, C_BR = 3, C_LOAD = 4, C_STORE = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    Op;
  logic [5:0]    Funct;
  logic          IRWrite, MDRWrite, PCWrite, RegWrite, mem_err;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  mc_seq_if mif ();

  mc_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .Op       (Op),
    .Funct    (Funct),
    .mem      (mif),
    .IRWrite  (IRWrite),
    .MDRWrite (MDRWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .state    (state),
    .mem_err  (mem_err),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: retire count, sticky error, and per-cycle expectations.
  logic [CW-1:0] instret_m = '0;
  logic          err_m     = 1'b0;
  logic [5:0]    cur_op    = 6'h00;
  logic [5:0]    cur_fn    = 6'h00;
  // {state[2:0], req, we, iord, irw, mdrw, pcw, regw, err, instret[3:0]}
  logic [14:0]   exp_q[$];

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cls;
    int         fw;
    int         dw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  // One clock cycle. Drive inputs just after the falling edge and record the expected outputs.
  task automatic cyc(input logic [2:0] st, input logic req, input logic we, input logic iord,
                     input logic irw, input logic mdrw, input logic pcw, input logic regw,
                     input logic rdy);
    @(negedge clk);
    Op = cur_op;
    Funct = cur_fn;
    mif.mem_ready = rdy;
    exp_q.push_back({st, req, we, iord, irw, mdrw, pcw, regw, err_m, instret_m});
    if (pcw) instret_m = instret_m + 4'd1;
  endtask

  // A memory access with a given number of wait cycles. If TO or more waits are
  // needed, the access times out.
  task automatic access(input logic [2:0] st, input logic we, input logic iord, input int waits,
                        input logic irw, input logic mdrw, input logic pcw, output bit ok);
    int n;
    n = (waits >= TO) ? TO : waits;
    for (int i = 0; i < n; i++) cyc(st, 1'b1, we, iord, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (waits >= TO) begin
      err_m = 1'b1;
      ok = 1'b0;
    end else begin
      cyc(st, 1'b1, we, iord, irw, mdrw, pcw, 1'b0, 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic run_instr(input vec_t v);
    bit ok;
    bit is_ls;
    cur_op = v.op;
    cur_fn = v.fn;
    access(3'd0, 1'b0, 1'b0, v.fw, 1'b1, 1'b0, 1'b0, ok);
    if (ok) begin
      cyc(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (v.cls == C_BR || v.cls == C_NOP), 1'b0, 1'b1);
      is_ls = (v.cls == C_LOAD || v.cls == C_STORE);
      if (is_ls)
        access(3'd3, (v.cls == C_STORE), 1'b1, v.dw, 1'b0, (v.cls == C_LOAD), (v.cls == C_STORE), ok);
      if (ok && (v.cls == C_LOAD || v.cls == C_ALU || v.cls == C_LINK))
        cyc(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i[0]);
  endtask

  // Assert reset between edges and release it just after a rising edge.
  task automatic do_reset;
    #3;
    rst = 1'b1;
    mif.mem_ready = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_instret", {28'd0, instret}, 32'd0);
    chk("rst_strobes", {28'd0, IRWrite, MDRWrite, PCWrite, RegWrite}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    instret_m = '0;
    err_m = 1'b0;
  endtask

  // Per-cycle comparison against the model. IorD only matters while a request is up.
  initial begin
    logic [14:0] e, g, m;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {state, mif.mem_req, mif.mem_we, mif.IorD, IRWrite, MDRWrite, PCWrite, RegWrite,
             mem_err, instret};
        m = e[11] ? 15'h7FFF : 15'h7DFF;
        n_total++;
        if ((g & m) === (e & m)) n_pass++;
        else $display("FAIL cycle@%0t got=%h expected=%h (state,req,we,iord,irw,mdrw,pcw,regw,err,instret)",
                      $time, g, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    Op = 6'h00;
    Funct = 6'h00;
    mif.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_mem_req", {31'd0, mif.mem_req}, 32'd0);
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_instret", {28'd0, instret}, 32'd0);
    chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
    chk("reset_strobes", {28'd0, IRWrite, MDRWrite, PCWrite, RegWrite}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add, lw (2 data waits), sw, beq, j
    vecs.push_back('{6'h00, 6'h20, C_ALU, 0, 0});
    vecs.push_back('{6'h23, 6'h00, C_LOAD, 0, 2});
    vecs.push_back('{6'h2B, 6'h00, C_STORE, 0, 0});
    vecs.push_back('{6'h04, 6'h00, C_BR, 0, 0});
    vecs.push_back('{6'h02, 6'h00, C_BR, 0, 0});
    run_instr(vecs[0]);
    @(posedge clk);
    #1;
    chk("add_instret", {28'd0, instret}, 32'd1);
    for (int i = 1; i < 5; i++) run_instr(vecs[i]);
    @(posedge clk);
    #1;
    chk("five_instret", {28'd0, instret}, 32'd5);

    // Remaining classes and the wait boundaries (TO-1 waits still complete).
    vecs.delete();
    vecs.push_back('{6'h03, 6'h00, C_LINK, 1, 0});
    vecs.push_back('{6'h00, 6'h09, C_LINK, 0, 0});
    vecs.push_back('{6'h00, 6'h08, C_BR, 0, 0});
    vecs.push_back('{6'h05, 6'h00, C_BR, 2, 0});
    vecs.push_back('{6'h08, 6'h00, C_ALU, 0, 0});
    vecs.push_back('{6'h0D, 6'h00, C_ALU, 0, 0});
    vecs.push_back('{6'h0C, 6'h00, C_ALU, 0, 0});
    vecs.push_back('{6'h0A, 6'h00, C_ALU, 0, 0});
    vecs.push_back('{6'h0F, 6'h00, C_ALU, 0, 0});
    vecs.push_back('{6'h20, 6'h00, C_LOAD, 0, 1});
    vecs.push_back('{6'h21, 6'h00, C_LOAD, 0, 0});
    vecs.push_back('{6'h24, 6'h00, C_LOAD, 1, 0});
    vecs.push_back('{6'h25, 6'h00, C_LOAD, 0, 3});
    vecs.push_back('{6'h28, 6'h00, C_STORE, 0, 3});
    vecs.push_back('{6'h29, 6'h00, C_STORE, 3, 0});
    vecs.push_back('{6'h00, 6'h22, C_ALU, 0, 0});
    vecs.push_back('{6'h3F, 6'h00, C_NOP, 0, 0});
    vecs.push_back('{6'h10, 6'h00, C_NOP, 0, 0});
    foreach (vecs[i]) run_instr(vecs[i]);
    @(posedge clk);
    #1;
    chk("wrap_instret", {28'd0, instret}, 32'd7);  // 23 retired, mod 16

    // Reset while FETCH is waiting.
    cur_op = 6'h00;
    cur_fn = 6'h20;
    cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("post_rst_instret", {28'd0, instret}, 32'd0);

    // Reset while a lw is waiting in MEM.
    cur_op = 6'h23;
    cur_fn = 6'h00;
    cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Fetch timeout: HALT after TO waits, mem_ready then ignored.
    run_instr('{6'h00, 6'h20, C_ALU, 4, 0});
    halt_cycles(4);
    @(posedge clk);
    #1;
    chk("halt_state", {29'd0, state}, 32'd5);
    chk("halt_mem_err", {31'd0, mem_err}, 32'd1);
    do_reset();
    chk("rst_clears_err", {31'd0, mem_err}, 32'd0);

    // Data timeout from MEM.
    run_instr('{6'h23, 6'h00, C_LOAD, 0, 4});
    halt_cycles(3);
    do_reset();

    run_instr('{6'h00, 6'h20, C_ALU, 0, 0});
    @(negedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
